// File: rtl/sram_dma_arb.sv
// SRAM port arbiter with a built-in word-copy DMA engine.
// The CPU always wins the port; the DMA engine only uses cycles where cpu_EN=0.
//
//   state  | meaning
//   IDLE   | no transfer; waits for dma_start
//   RD     | presents the source address when the port is free
//   WAIT   | captures the read word from sram_DO
//   WR     | writes the buffered word to the destination when the port is free
module sram_dma_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ADDR,
  input  logic [DATA_W-1:0] cpu_DI,
  input  logic              cpu_EN,
  input  logic              cpu_WE,
  output logic [DATA_W-1:0] cpu_DO,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [15:0]       dma_len,
  input  logic              dma_start,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [15:0]       dma_remaining
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [15:0]       rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              done_q, done_d;
  logic              dma_grant;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (dma_start && !done_q) begin
          src_d = dma_src;
          dst_d = dma_dst;
          rem_d = dma_len;
          if (dma_len == 16'd0) done_d = 1'b1;
          else                  state_d = S_RD;
        end
      end
      S_RD: begin
        if (dma_grant) begin
          src_d   = src_q + ADDR_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // sram_DO still carries the RD data even if the CPU took this cycle.
        buf_d   = sram_DO;
        state_d = S_WR;
      end
      S_WR: begin
        if (dma_grant) begin
          dst_d = dst_q + ADDR_W'(1);
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port arbitration and status outputs.
  always_comb begin
    // Blocking the grant during reset keeps an aborted transfer from writing.
    dma_grant = !cpu_EN && !reset && ((state_q == S_RD) || (state_q == S_WR));
    sram_ADDR = cpu_ADDR;
    sram_DI   = cpu_DI;
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;
    if (cpu_EN) begin
      sram_EN = 1'b1;
      sram_WE = cpu_WE;
    end else if (dma_grant) begin
      sram_ADDR = (state_q == S_WR) ? dst_q : src_q;
      sram_DI   = buf_q;
      sram_EN   = 1'b1;
      sram_WE   = (state_q == S_WR);
    end
    cpu_DO        = sram_DO;
    dma_busy      = (state_q != S_IDLE);
    dma_done      = done_q;
    dma_remaining = rem_q;
  end

endmodule

// File: doc/sram_dma_arb.md
Name: sram_dma_arb

Overview:
- Owns the single SRAM port and shares it between the CPU controller and a built-in word-copy DMA engine.
- The CPU has fixed priority. The DMA engine uses only cycles in which the CPU is not accessing memory.
- Software-visible config inputs (src, dst, len, start) drive the DMA. Status outputs report progress.
- Sits between the CPU controller and the SRAM in the top level, replacing the direct CPU-to-SRAM connection.

Parameters:
- ADDR_W, 16, SRAM word-address width.
- DATA_W, 32, SRAM data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_ADDR  input  ADDR_W  CPU word address.
- cpu_DI  input  DATA_W  CPU write data.
- cpu_EN  input  1  CPU access request; 1 means the CPU owns the port this cycle.
- cpu_WE  input  1  CPU write enable; meaningful only when cpu_EN=1.
- cpu_DO  output  DATA_W  read data to the CPU; equals sram_DO.
- sram_ADDR  output  ADDR_W  address to the SRAM.
- sram_DI  output  DATA_W  write data to the SRAM.
- sram_EN  output  1  SRAM enable.
- sram_WE  output  1  SRAM write enable.
- sram_DO  input  DATA_W  SRAM read data; valid one cycle after the address is presented.
- dma_src  input  ADDR_W  source start address; sampled on an accepted start.
- dma_dst  input  ADDR_W  destination start address; sampled on an accepted start.
- dma_len  input  16  number of words to copy; sampled on an accepted start.
- dma_start  input  1  start request; honoured only in IDLE.
- dma_busy  output  1  high while the engine is not in IDLE.
- dma_done  output  1  one-cycle pulse when a transfer completes.
- dma_remaining  output  16  words not yet written.

Behaviour:
- Reset:
  - FSM goes to IDLE; dma_busy=0, dma_done=0, dma_remaining=0.
  - Internal src/dst pointers and the data buffer clear to 0.
  - Reset mid-transfer aborts it immediately. No further DMA write is issued. No done pulse is generated.
- SRAM memory model: read data on sram_DO is valid in the cycle after the address. A write occurs at the rising edge where sram_EN=1 and sram_WE=1.
- Arbitration (combinational):
  - dma_grant = cpu_EN==0 and state is RD or WR.
  - If cpu_EN=1: sram_ADDR=cpu_ADDR, sram_DI=cpu_DI, sram_WE=cpu_WE, sram_EN=1.
  - Else if dma_grant: sram_ADDR = src pointer (RD) or dst pointer (WR); sram_DI = buffer; sram_WE=1 only in WR; sram_EN=1.
  - Otherwise sram_EN=0, sram_WE=0, sram_ADDR=cpu_ADDR.
  - The CPU is never stalled. The DMA engine waits indefinitely while cpu_EN=1; starvation is acceptable.
- FSM states: IDLE, RD, WAIT, WR.
  - IDLE + dma_start:
    - Load src, dst and remaining from dma_src, dma_dst and dma_len.
    - If dma_len=0: stay in IDLE and pulse dma_done next cycle.
    - Otherwise go to RD.
  - RD: hold until dma_grant. On grant, src <= src+1 and go to WAIT.
  - WAIT: buffer <= sram_DO, captured unconditionally even if the CPU owns the port this cycle. Go to WR.
  - WR: hold until dma_grant. On grant:
    - dst <= dst+1, remaining <= remaining-1.
    - If remaining was 1: go to IDLE with dma_done=1 for one cycle.
    - Otherwise go to RD.
- dma_start while busy is ignored; inputs are not resampled.
- Pointers wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000). Overlapping regions are copied word-sequentially in ascending order with no overlap correction.
- Uncontended timing for N words:
  - Busy lasts 3N cycles.
  - dma_done goes high in the cycle dma_busy falls.
- Same cycle as dma_done, dma_start is ignored; a new start is accepted from the next cycle.

Test Plan:
- CPU pass-through: DMA idle, cpu_EN=1, cpu_WE=1, addr 0x0010, data 0xDEADBEEF -> SRAM outputs mirror the CPU inputs. Next cycle, a read of 0x0010 returns 0xDEADBEEF on cpu_DO one cycle later.
- Uncontended copy: mem[0x100..0x103]=1,2,3,4; src=0x100, dst=0x200, len=4, cpu_EN=0 -> busy for 12 cycles, dma_remaining counts 4->0, mem[0x200..0x203]=1,2,3,4, single dma_done pulse.
- Contention: same copy, cpu_EN=1 on alternating cycles -> no DMA access in any cpu_EN=1 cycle, CPU accesses unaffected, final memory identical; WAIT capture is correct even when the CPU owns the port in that cycle.
- Boundary cases:
  - len=0 -> no SRAM access, dma_done pulses once, busy never rises.
  - src=0xFFFF, len=2 -> reads 0xFFFF then 0x0000.
- Restart/abort:
  - dma_start pulsed mid-transfer -> ignored; original length completes.
  - reset asserted after the 2nd write of a len=4 copy -> only 2 destination words are modified, busy=0, no dma_done.
